// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised 16x-oversampling UART receiver; optional parity via UART_RX_PARITY_EN
module uart_rx_param #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DATA_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [2:0]        Baud_set,
    input  logic              Rx,
`ifdef UART_RX_PARITY_EN
    input  logic              Parity_odd,
    output logic              Parity_err,
`endif
    output logic [DATA_W-1:0] Data,
    output logic              Rx_Done,
    output logic              Frame_err
);

    localparam int CW       = $clog2(CLK_FREQ / (9600 * 16));
    localparam int DIV_9600 = CLK_FREQ / (9600 * 16) - 1;
    localparam int DIV_19K2 = CLK_FREQ / (19200 * 16) - 1;
    localparam int DIV_38K4 = CLK_FREQ / (38400 * 16) - 1;
    localparam int DIV_57K6 = CLK_FREQ / (57600 * 16) - 1;
    localparam int DIV_115K = CLK_FREQ / (115200 * 16) - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic              rx_s1, rx_s2, rx_h;
    logic              start_edge;
    logic [2:0]        state;
    logic [2:0]        baud_r;
    logic [CW-1:0]     div_cnt, div_max;
    logic              tick;
    logic [3:0]        samp_cnt;
    logic [3:0]        bit_idx;
    logic [2:0]        ones, ones_nxt;
    logic              samp_win;
    logic              vote;
    logic [DATA_W-1:0] shift;
`ifdef UART_RX_PARITY_EN
    logic              par_flag;
`endif

    // History FF keeps running in every state so a start bit directly after a stop bit is still seen
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_h  <= 1'b1;
        end else begin
            rx_s1 <= Rx;
            rx_s2 <= rx_s1;
            rx_h  <= rx_s2;
        end
    end

    assign start_edge = rx_h & ~rx_s2;

    always_comb begin
        case (baud_r)
            3'd1:    div_max = CW'(DIV_19K2);
            3'd2:    div_max = CW'(DIV_38K4);
            3'd3:    div_max = CW'(DIV_57K6);
            3'd4:    div_max = CW'(DIV_115K);
            default: div_max = CW'(DIV_9600);
        endcase
    end

    assign tick     = (state != S_IDLE) && (div_cnt == div_max);
    assign samp_win = (samp_cnt >= 4'd5) && (samp_cnt <= 4'd11);
    assign ones_nxt = ones + {2'b00, samp_win & rx_s2};
    // At tick 11 the vote already includes that tick's sample
    assign vote     = (ones_nxt >= 3'd4);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            baud_r    <= 3'd0;
            div_cnt   <= '0;
            samp_cnt  <= 4'd0;
            bit_idx   <= 4'd0;
            ones      <= 3'd0;
            shift     <= '0;
            Data      <= '0;
            Rx_Done   <= 1'b0;
            Frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag   <= 1'b0;
            Parity_err <= 1'b0;
`endif
        end else begin
            Rx_Done <= 1'b0;
            if (state == S_IDLE) begin
                div_cnt  <= '0;
                samp_cnt <= 4'd0;
                bit_idx  <= 4'd0;
                ones     <= 3'd0;
                if (start_edge) begin
                    baud_r <= Baud_set;
                    state  <= S_START;
`ifdef UART_RX_PARITY_EN
                    par_flag <= 1'b0;
`endif
                end
            end else if (tick) begin
                div_cnt  <= '0;
                samp_cnt <= samp_cnt + 4'd1;
                ones     <= (samp_cnt == 4'd0) ? 3'd0 : ones_nxt;
                case (state)
                    S_START: begin
                        if (samp_cnt == 4'd11 && vote)
                            state <= S_IDLE;
                        else if (samp_cnt == 4'd15)
                            state <= S_DATA;
                    end
                    S_DATA: begin
                        if (samp_cnt == 4'd15) begin
                            // Right shift: after DATA_W bits the first (LSB) bit sits at index 0
                            shift   <= {vote, shift[DATA_W-1:1]};
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (samp_cnt == 4'd15) begin
                            par_flag <= (^shift) ^ vote ^ Parity_odd;
                            state    <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (samp_cnt == 4'd11) begin
                            Data      <= shift;
                            Frame_err <= ~vote;
                            Rx_Done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            Parity_err <= par_flag;
`endif
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param with random frames and a frame-level model
module tb_uart_rx_param;

    localparam int BIT115 = 8680;
    localparam int BIT57  = 17280;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [2:0] Baud_set;
    logic       Rx;
    logic [7:0] Data;
    logic       Rx_Done;
    logic       Frame_err;
`ifdef UART_RX_PARITY_EN
    logic       Parity_odd;
    logic       Parity_err;
`endif

    uart_rx_param #(.CLK_FREQ(50_000_000), .DATA_W(8)) dut (
        .Clk       (clk),
        .Reset_n   (Reset_n),
        .Baud_set  (Baud_set),
        .Rx        (Rx),
`ifdef UART_RX_PARITY_EN
        .Parity_odd(Parity_odd),
        .Parity_err(Parity_err),
`endif
        .Data      (Data),
        .Rx_Done   (Rx_Done),
        .Frame_err (Frame_err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // {parity_err, frame_err, data}
    logic [9:0] sb[$];
    logic [7:0] exp_data = 8'h00;
    logic       exp_ferr = 1'b0;
    logic       exp_perr = 1'b0;
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic parity_error(input logic [7:0] d, input logic pbit, input logic odd);
        int ones;
        ones = pbit;
        for (int i = 0; i < 8; i++) ones += d[i];
        return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    always @(negedge clk) begin
        logic [9:0] e;
        if (!Reset_n) begin
            chk("reset_data", Data, 0);
            chk("reset_done", Rx_Done, 0);
            chk("reset_ferr", Frame_err, 0);
`ifdef UART_RX_PARITY_EN
            chk("reset_perr", Parity_err, 0);
`endif
            exp_data  = 8'h00;
            exp_ferr  = 1'b0;
            exp_perr  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (Rx_Done) begin
                chk("done_width", prev_done, 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got Rx_Done=1 with Data=%0h expected no frame at %0t", Data, $time);
                end else begin
                    e = sb.pop_front();
                    exp_data = e[7:0];
                    exp_ferr = e[8];
                    exp_perr = e[9];
                    chk("data", Data, exp_data);
                    chk("frame_err", Frame_err, exp_ferr);
`ifdef UART_RX_PARITY_EN
                    chk("parity_err", Parity_err, exp_perr);
`endif
                end
            end else begin
                chk("data_hold", Data, exp_data);
                chk("ferr_hold", Frame_err, exp_ferr);
`ifdef UART_RX_PARITY_EN
                chk("perr_hold", Parity_err, exp_perr);
`endif
            end
            prev_done = Rx_Done;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit, input int bit_ns);
        logic perr;
        perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr = parity_error(d, par_bit, Parity_odd);
`endif
        sb.push_back({perr, ~stop_bit, d});
        Rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            #(bit_ns);
        end
`ifdef UART_RX_PARITY_EN
        Rx = par_bit;
        #(bit_ns);
`endif
        Rx = stop_bit;
        #(bit_ns);
        Rx = 1'b1;
    endtask

    function automatic logic good_parity(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
        return parity_error(d, 1'b0, Parity_odd);
`else
        return ^d;
`endif
    endfunction

    initial begin
        logic [7:0] d;
        Reset_n  = 1'b0;
        Baud_set = 3'd4;
        Rx       = 1'b1;
`ifdef UART_RX_PARITY_EN
        Parity_odd = 1'b0;
`endif
        #103;
        Reset_n = 1'b1;
        #400;

        send_frame(8'h5A, 1'b1, good_parity(8'h5A), BIT115);
        #(BIT115);
        send_frame(8'hA5, 1'b1, good_parity(8'hA5), BIT115);
        #(BIT115);
        send_frame(8'h86, 1'b1, good_parity(8'h86), BIT115);
        #(BIT115);

        // Glitch shorter than the sample window must not produce a frame
        Rx = 1'b0;
        #200;
        Rx = 1'b1;
        #(2 * BIT115);
        send_frame(8'h3C, 1'b1, good_parity(8'h3C), BIT115);
        #(BIT115);

        // Framing error, then the line stays low with no new falling edge
        send_frame(8'h81, 1'b0, good_parity(8'h81), BIT115);
        Rx = 1'b0;
        #(3 * BIT115);
        Rx = 1'b1;
        #(2 * BIT115);

        send_frame(8'h55, 1'b1, good_parity(8'h55), BIT115);
        send_frame(8'hAA, 1'b1, good_parity(8'hAA), BIT115);
        #(BIT115);

        // Reset during data bit 4 aborts the frame
        d = 8'hA6;
        Rx = 1'b0;
        #(BIT115);
        for (int i = 0; i < 4; i++) begin
            Rx = d[i];
            #(BIT115);
        end
        Rx = d[4];
        #4340;
        Reset_n = 1'b0;
        Rx = 1'b1;
        #2000;
        Reset_n = 1'b1;
        #(2 * BIT115);
        send_frame(8'hC3, 1'b1, good_parity(8'hC3), BIT115);
        #(BIT115);

        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, good_parity(d), BIT115);
            #($urandom_range(0, 2) * BIT115 + $urandom_range(0, 50) * 20);
        end

        // Baud_set changed mid-frame must be ignored
        Baud_set = 3'd3;
        #200;
        d = 8'($urandom);
        fork
            send_frame(d, 1'b1, good_parity(d), BIT57);
            begin
                #(3 * BIT57);
                Baud_set = 3'd0;
            end
        join
        Baud_set = 3'd4;
        #(BIT115);

`ifdef UART_RX_PARITY_EN
        Parity_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, BIT115);
        #(BIT115);
        send_frame(8'h07, 1'b1, 1'b1, BIT115);
        #(BIT115);
`endif

        for (int i = 0; i < 20000 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", sb.size(), 0);
        #(2 * BIT115);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
